watch_set_ctrl: RTL and testbench

- Timekeeping and time-setting controller for the 6-digit watch.
- Holds the time as BCD hh:mm:ss and advances it once per second from a 2 Hz strobe.
- Sequences a set mode driven by two buttons: MODE steps through hours, minutes and seconds; INC changes the field being edited.
- Drives the six BCD digit inputs of the multiplexed display. The field being edited is blanked at 1 Hz so the user can see which one it is.

---
 rtl/watch_pkg.sv | 16 +
 rtl/watch_set_ctrl_bcd2.sv | 60 ++++++
 rtl/watch_set_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_watch_set_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch
// timekeeping and time-setting controller.
package watch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } watch_state_t;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;
  localparam logic [7:0] H_MAX       = 8'h23;
  localparam logic [7:0] MS_MAX      = 8'h59;

endpackage

// File: rtl/watch_set_ctrl_bcd2.sv
// Two-digit BCD field counter with wrap at MAX,
// clear, and a registered blankable display copy.
import watch_pkg::*;

module bcd2_counter #(
  parameter logic [7:0] MAX = 8'h59
)(
  input  logic       clk_i,
  input  logic       a_reset_i,
  input  logic       inc_i,
  input  logic       clr_i,
  input  logic       blank_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       carry_o
);

  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic [3:0] w_tens;
  logic [3:0] w_ones;

  // next field value: clear beats increment, wrap at MAX
  always_comb begin
    w_tens  = r_tens;
    w_ones  = r_ones;
    carry_o = 1'b0;
    if (clr_i) begin
      w_tens = 4'd0;
      w_ones = 4'd0;
    end else if (inc_i) begin
      if ({r_tens, r_ones} == MAX) begin
        w_tens  = 4'd0;
        w_ones  = 4'd0;
        carry_o = 1'b1;
      end else if (r_ones == 4'd9) begin
        w_ones = 4'd0;
        w_tens = r_tens + 4'd1;
      end else begin
        w_ones = r_ones + 4'd1;
      end
    end
  end

  // stored time plus display copy, both updated together
  always_ff @(posedge clk_i or negedge a_reset_i) begin
    if (!a_reset_i) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
      tens_o <= 4'd0;
      ones_o <= 4'd0;
    end else begin
      r_tens <= w_tens;
      r_ones <= w_ones;
      tens_o <= blank_i ? BLANK_DIGIT : w_tens;
      ones_o <= blank_i ? BLANK_DIGIT : w_ones;
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// Watch controller: hh:mm:ss timekeeping, MODE/INC
// set sequence with timeout, and 1 Hz field blink.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = 10
)(
  input  logic       clk_i,
  input  logic       a_reset_i,
  input  logic       tick_2hz_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  output logic [3:0] h_t_o,
  output logic [3:0] h_o_o,
  output logic [3:0] m_t_o,
  output logic [3:0] m_o_o,
  output logic [3:0] s_t_o,
  output logic [3:0] s_o_o,
  output logic [1:0] mode_o,
  output logic       edit_o
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_S - 1);

  logic         r_rst_meta;
  logic         r_rst_n;
  logic         r_mode_q;
  logic         r_inc_q;
  logic         r_half;
  logic         r_blink;
  logic         r_edit;
  logic [7:0]   r_to;
  watch_state_t r_state;
  watch_state_t w_state_nxt;

  logic w_mode_edge;
  logic w_inc_raw;
  logic w_inc_edge;
  logic w_any_edge;
  logic w_in_set;
  logic w_run;
  logic w_sec;
  logic w_adv;
  logic w_to_hit;
  logic w_leave;
  logic w_blink_nxt;
  logic w_edit_nxt;
  logic w_blank_h;
  logic w_blank_m;
  logic w_blank_s;
  logic w_s_carry;
  logic w_m_carry;
  logic w_unused_h_carry;
  logic w_s_inc;
  logic w_s_clr;
  logic w_m_inc;
  logic w_h_inc;

  assign w_mode_edge = btn_mode_i & ~r_mode_q;
  assign w_inc_raw   = btn_inc_i & ~r_inc_q;
  assign w_inc_edge  = w_inc_raw & ~w_mode_edge;
  assign w_any_edge  = w_mode_edge | w_inc_raw;
  assign w_in_set    = (r_state != RUN);
  assign w_run       = (r_state == RUN);
  assign w_sec       = tick_2hz_i & r_half;
  assign w_adv       = w_run & w_sec;
  assign w_to_hit    = w_in_set & w_sec & ~w_inc_edge
                     & (r_to == TO_LAST);
  assign w_leave     = w_in_set & (w_state_nxt == RUN);

  assign w_s_inc = w_adv;
  assign w_s_clr = (r_state == SET_S) & w_inc_edge;
  assign w_m_inc = (w_run & w_s_carry)
                 | ((r_state == SET_M) & w_inc_edge);
  assign w_h_inc = (w_run & w_m_carry)
                 | ((r_state == SET_H) & w_inc_edge);

  assign mode_o = r_state;
  assign edit_o = r_edit;

  // async assert, clocked release of the internal reset
  always_ff @(posedge clk_i or negedge a_reset_i) begin
    if (!a_reset_i) begin
      r_rst_meta <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_n    <= r_rst_meta;
    end
  end

  // button level history for rising-edge detection
  always_ff @(posedge clk_i or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_mode_q <= 1'b0;
      r_inc_q  <= 1'b0;
    end else begin
      r_mode_q <= btn_mode_i;
      r_inc_q  <= btn_inc_i;
    end
  end

  // state register
  always_ff @(posedge clk_i or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next state: timeout to RUN dominates a MODE step
  always_comb begin
    w_state_nxt = r_state;
    if (w_to_hit) begin
      w_state_nxt = RUN;
    end else if (w_mode_edge) begin
      unique case (r_state)
        RUN:     w_state_nxt = SET_H;
        SET_H:   w_state_nxt = SET_M;
        SET_M:   w_state_nxt = SET_S;
        default: w_state_nxt = RUN;
      endcase
    end
  end

  // blink phase and field-blank selects for next cycle
  always_comb begin
    w_blink_nxt = r_blink;
    w_blank_h   = 1'b0;
    w_blank_m   = 1'b0;
    w_blank_s   = 1'b0;
    w_edit_nxt  = (w_state_nxt != RUN);
    if (w_state_nxt == RUN) begin
      w_blink_nxt = 1'b0;
    end else if (w_in_set && w_inc_edge) begin
      w_blink_nxt = 1'b0;
    end else if (tick_2hz_i) begin
      w_blink_nxt = ~r_blink;
    end
    unique case (w_state_nxt)
      SET_H:   w_blank_h = w_blink_nxt;
      SET_M:   w_blank_m = w_blink_nxt;
      SET_S:   w_blank_s = w_blink_nxt;
      default: ;
    endcase
  end

  // half-second phase, blink phase and edit flag
  always_ff @(posedge clk_i or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_half  <= 1'b0;
      r_blink <= 1'b0;
      r_edit  <= 1'b0;
    end else begin
      if (w_leave) begin
        r_half <= 1'b0;
      end else if (tick_2hz_i) begin
        r_half <= ~r_half;
      end
      r_blink <= w_blink_nxt;
      r_edit  <= w_edit_nxt;
    end
  end

  // idle-seconds counter for the SET timeout
  always_ff @(posedge clk_i or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_to <= 8'd0;
    end else if (w_any_edge || w_to_hit || !w_in_set) begin
      r_to <= 8'd0;
    end else if (w_sec) begin
      r_to <= r_to + 8'd1;
    end
  end

  bcd2_counter #(.MAX(MS_MAX)) u_sec (
    .clk_i     (clk_i),
    .a_reset_i (r_rst_n),
    .inc_i     (w_s_inc),
    .clr_i     (w_s_clr),
    .blank_i   (w_blank_s),
    .tens_o    (s_t_o),
    .ones_o    (s_o_o),
    .carry_o   (w_s_carry)
  );

  bcd2_counter #(.MAX(MS_MAX)) u_min (
    .clk_i     (clk_i),
    .a_reset_i (r_rst_n),
    .inc_i     (w_m_inc),
    .clr_i     (1'b0),
    .blank_i   (w_blank_m),
    .tens_o    (m_t_o),
    .ones_o    (m_o_o),
    .carry_o   (w_m_carry)
  );

  bcd2_counter #(.MAX(H_MAX)) u_hr (
    .clk_i     (clk_i),
    .a_reset_i (r_rst_n),
    .inc_i     (w_h_inc),
    .clr_i     (1'b0),
    .blank_i   (w_blank_h),
    .tens_o    (h_t_o),
    .ones_o    (h_o_o),
    .carry_o   (w_unused_h_carry)
  );

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl.
// Scoreboard queue plus a tick-count vector table.
module tb_watch_set_ctrl;

  localparam int TO = 10;

  logic       clk_i = 1'b0;
  logic       a_reset_i = 1'b1;
  logic       tick_2hz_i = 1'b0;
  logic       btn_mode_i = 1'b0;
  logic       btn_inc_i = 1'b0;
  logic [3:0] h_t_o, h_o_o, m_t_o, m_o_o, s_t_o, s_o_o;
  logic [1:0] mode_o;
  logic       edit_o;
  logic [23:0] w_dig;

  assign w_dig = {h_t_o, h_o_o, m_t_o, m_o_o, s_t_o, s_o_o};

  always #5 clk_i = ~clk_i;

  watch_set_ctrl #(.TIMEOUT_S(TO)) dut (
    .clk_i      (clk_i),
    .a_reset_i  (a_reset_i),
    .tick_2hz_i (tick_2hz_i),
    .btn_mode_i (btn_mode_i),
    .btn_inc_i  (btn_inc_i),
    .h_t_o      (h_t_o),
    .h_o_o      (h_o_o),
    .m_t_o      (m_t_o),
    .m_o_o      (m_o_o),
    .s_t_o      (s_t_o),
    .s_o_o      (s_o_o),
    .mode_o     (mode_o),
    .edit_o     (edit_o)
  );

  typedef struct {
    string       nm;
    logic [23:0] dig;
    bit          cd;
    logic [1:0]  md;
  } exp_t;

  typedef struct {
    int          n;
    logic [23:0] dig;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   run_mode_err = 0;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_tick();
    tick_2hz_i = 1'b1;
    step();
    tick_2hz_i = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic press(input bit m, input bit c);
    btn_mode_i = m;
    btn_inc_i  = c;
    step();
    btn_mode_i = 1'b0;
    btn_inc_i  = 1'b0;
    step();
  endtask

  task automatic sb_push(input string nm, input logic [23:0] dig,
                         input bit cd, input logic [1:0] md);
    exp_t e;
    e.nm  = nm;
    e.dig = dig;
    e.cd  = cd;
    e.md  = md;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop();
    exp_t e;
    bit   bad;
    logic want_edit;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL sb_empty: no expectation queued");
      return;
    end
    e = sb_q.pop_front();
    want_edit = (e.md != 2'd0);
    bad = (mode_o !== e.md) || (edit_o !== want_edit)
        || (e.cd && (w_dig !== e.dig));
    if (bad) begin
      failures++;
      $display("FAIL %s: got dig=%h mode=%0d edit=%b, want dig=%h mode=%0d edit=%b",
               e.nm, w_dig, mode_o, edit_o, e.dig, e.md, want_edit);
    end
  endtask

  task automatic tick_chk(input int n, input string nm,
                          input logic [23:0] dig, input bit cd,
                          input logic [1:0] md);
    if (n > 1) ticks(n - 1);
    sb_push(nm, dig, cd, md);
    do_tick();
    sb_pop();
  endtask

  task automatic press_chk(input int n, input bit m, input bit c,
                           input string nm, input logic [23:0] dig,
                           input logic [1:0] md);
    for (int i = 1; i < n; i++) press(m, c);
    sb_push(nm, dig, 1'b1, md);
    press(m, c);
    sb_pop();
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{n: 1,   dig: 24'h000000};
    vecs[1] = '{n: 1,   dig: 24'h000001};
    vecs[2] = '{n: 18,  dig: 24'h000010};
    vecs[3] = '{n: 100, dig: 24'h000100};

    #2 a_reset_i = 1'b0;
    step();
    step();
    sb_push("reset", 24'h000000, 1'b1, 2'd0);
    sb_pop();
    a_reset_i = 1'b1;
    repeat (4) step();

    // free-running from reset: 120 ticks -> one minute
    for (int i = 0; i < 4; i++) begin
      for (int k = 1; k < vecs[i].n; k++) begin
        do_tick();
        if (mode_o !== 2'd0) run_mode_err++;
      end
      sb_push($sformatf("run_vec%0d", i), vecs[i].dig, 1'b1, 2'd0);
      do_tick();
      sb_pop();
    end
    checks++;
    if (run_mode_err != 0) begin
      failures++;
      $display("FAIL run_mode: got %0d nonzero samples, want 0",
               run_mode_err);
    end

    // preload 23:59:00 via SET, then run to the day wrap
    press_chk(1, 1, 0, "enter_set_h", 24'h000100, 2'd1);
    press_chk(23, 0, 1, "set_h_23", 24'h230100, 2'd1);
    press_chk(1, 1, 0, "enter_set_m", 24'h230100, 2'd2);
    press_chk(58, 0, 1, "set_m_59", 24'h235900, 2'd2);
    press_chk(1, 1, 0, "enter_set_s", 24'h235900, 2'd3);
    press_chk(1, 1, 0, "back_run", 24'h235900, 2'd0);
    tick_chk(116, "run_235958", 24'h235958, 1'b1, 2'd0);
    tick_chk(2, "run_235959", 24'h235959, 1'b1, 2'd0);
    tick_chk(2, "day_wrap", 24'h000000, 1'b1, 2'd0);

    // SET_H: hour wrap, blink and INC unblank
    press_chk(1, 1, 0, "set_h_again", 24'h000000, 2'd1);
    press_chk(21, 0, 1, "set_h_21", 24'h210000, 2'd1);
    press_chk(4, 0, 1, "set_h_01", 24'h010000, 2'd1);
    tick_chk(1, "h_blank0", 24'hFF0000, 1'b1, 2'd1);
    tick_chk(1, "h_show0", 24'h010000, 1'b1, 2'd1);
    tick_chk(1, "h_blank1", 24'hFF0000, 1'b1, 2'd1);
    press_chk(1, 0, 1, "inc_unblank", 24'h020000, 2'd1);
    tick_chk(1, "h_blank2", 24'hFF0000, 1'b1, 2'd1);
    tick_chk(1, "h_show2", 24'h020000, 1'b1, 2'd1);

    // SET_M: wrap with no carry, then MODE+INC together
    press_chk(1, 1, 0, "enter_set_m2", 24'h020000, 2'd2);
    press_chk(59, 0, 1, "m_59", 24'h025900, 2'd2);
    press_chk(1, 0, 1, "m_wrap", 24'h020000, 2'd2);
    press_chk(1, 0, 1, "m_01", 24'h020100, 2'd2);
    press_chk(1, 1, 1, "mode_wins", 24'h020100, 2'd3);

    // SET_S idle timeout: first tick is a second strobe here
    tick_chk(17, "to_s_blank", 24'h0201FF, 1'b1, 2'd3);
    tick_chk(1, "to_before", 24'h020100, 1'b1, 2'd3);
    tick_chk(1, "to_exit", 24'h020100, 1'b1, 2'd0);
    tick_chk(1, "to_half0", 24'h020100, 1'b1, 2'd0);
    tick_chk(1, "to_first_adv", 24'h020101, 1'b1, 2'd0);

    // timeout restarts from an INC edge
    press(1, 0);
    press(1, 0);
    press_chk(1, 1, 0, "enter_set_s2", 24'h020101, 2'd3);
    ticks(10);
    press_chk(1, 0, 1, "s_clear", 24'h020100, 2'd3);
    tick_chk(19, "to2_before", 24'h0201FF, 1'b1, 2'd3);
    tick_chk(1, "to2_exit", 24'h020100, 1'b1, 2'd0);

    // async reset in SET_M with minutes blanked
    press(1, 0);
    press_chk(1, 1, 0, "enter_set_m3", 24'h020100, 2'd2);
    tick_chk(1, "m_blank", 24'h02FF00, 1'b1, 2'd2);
    sb_push("async_reset", 24'h000000, 1'b1, 2'd0);
    #2 a_reset_i = 1'b0;
    #1 sb_pop();
    step();
    step();
    a_reset_i = 1'b1;
    repeat (4) step();
    sb_push("post_reset", 24'h000000, 1'b1, 2'd0);
    sb_pop();
    tick_chk(2, "post_reset_adv", 24'h000001, 1'b1, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
